// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX path (and the future RX path).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered, back-pressured UART transmitter (8N1/8N2).
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_valid,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int STOP_W   = $clog2(STOP_LEN);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: DEPTH must be a power of two >= 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_buffered: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t                 state;
  tx_state_t                 state_next;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [STOP_W-1:0]         stop_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_data;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      bit_done;
  logic                      stop_done;
`ifdef UART_TX_PARITY_EN
  logic                      parity_bit;
`endif

  assign wr_ready  = !RST && !fifo_full;
  assign push      = wr_valid && wr_ready;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign stop_done = (stop_cnt == STOP_LAST);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (level)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP: begin
        // Back-to-back frames: pop on the stop exit edge so no idle gap appears.
        if (stop_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx = UART_IDLE_LEVEL;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift_data[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = parity_bit;
`endif
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      stop_cnt   <= '0;
      bit_idx    <= '0;
      shift_data <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= (state == IDLE || bit_done) ? '0 : baud_cnt + 1'b1;
      stop_cnt <= (state == STOP && !stop_done) ? stop_cnt + 1'b1 : '0;
      if (state == DATA && bit_done) bit_idx <= bit_idx + 1'b1;
      if (pop) begin
        shift_data <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^fifo_rd_data;
`endif
      end else if (state == DATA && bit_done) begin
        shift_data <= shift_data >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: two instances (1 and 2 stop bits), DEPTH=4, 4 clocks per bit.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int FRAME_A = (10 + PBIT) * CPB;
  localparam int FRAME_B = (11 + PBIT) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid_a, wr_valid_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic       wr_ready_a, wr_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic [2:0] level_a, level_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] sa [8];
  logic [7:0] sb [8];
  int         na, nb, t0a, t0b, n;
  bit         act_a, act_b;

  uart_tx_buffered #(.DEPTH(4), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .CLK(clk), .RST(rst), .wr_valid(wr_valid_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready_a), .tx(tx_a), .busy(busy_a), .level(level_a)
  );

  uart_tx_buffered #(.DEPTH(4), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .CLK(clk), .RST(rst), .wr_valid(wr_valid_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b), .tx(tx_b), .busy(busy_b), .level(level_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Slot 0 start, slots 1..8 data LSB first, optional parity, then stop/idle high.
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PBIT == 1 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic step();
    int t;
    logic e;
    @(negedge clk);
    if (act_a) begin
      t = cyc - t0a;
      e = (t >= 0 && t / FRAME_A < na) ? frame_bit(sa[t / FRAME_A], (t % FRAME_A) / CPB) : 1'b1;
      chk("tx_a", tx_a, e);
    end
    if (act_b) begin
      t = cyc - t0b;
      e = (t >= 0 && t / FRAME_B < nb) ? frame_bit(sb[t / FRAME_B], (t % FRAME_B) / CPB) : 1'b1;
      chk("tx_b", tx_b, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_valid_a = 1'b0; wr_data_a = '0;
    wr_valid_b = 1'b0; wr_data_b = '0;
    act_a = 1'b0; act_b = 1'b0; na = 0; nb = 0; t0a = 0; t0b = 0;

    // Reset state
    step(); step();
    chk("rst_tx_a", tx_a, 1'b1);
    chk("rst_ready_a", wr_ready_a, 1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_level_a", level_a, 3'd0);
    chk("rst_tx_b", tx_b, 1'b1);
    chk("rst_ready_b", wr_ready_b, 1'b0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", wr_ready_a, 1'b1);

    // Basic frame: 0xA5
    wr_valid_a = 1'b1; wr_data_a = 8'hA5;
    step();
    wr_valid_a = 1'b0;
    chk("basic_level", level_a, 3'd1);
    chk("basic_busy", busy_a, 1'b1);
    chk("basic_tx_idle", tx_a, 1'b1);
    sa[0] = 8'hA5; na = 1; t0a = cyc + 1; act_a = 1'b1;
    n = 0;
    while (busy_a && n < 200) begin step(); n++; end
    chk("basic_busy_len", n, FRAME_A + 1);

    // Fill and back-pressure with 6 bytes (first two exercise parity 1 then 0)
    sa[0] = 8'h07; sa[1] = 8'h03; sa[2] = 8'hA5; sa[3] = 8'h5A; sa[4] = 8'hC3; sa[5] = 8'h81;
    act_a = 1'b0;
    wr_valid_a = 1'b1; wr_data_a = sa[0];
    step();
    chk("fill_level1", level_a, 3'd1);
    chk("fill_tx_idle", tx_a, 1'b1);
    na = 6; t0a = cyc + 1; act_a = 1'b1;
    wr_data_a = sa[1];
    step();
    chk("fill_pop_push", level_a, 3'd1);
    wr_data_a = sa[2];
    step();
    chk("fill_level2", level_a, 3'd2);
    wr_data_a = sa[3];
    step();
    chk("fill_level3", level_a, 3'd3);
    wr_data_a = sa[4];
    step();
    chk("fill_level4", level_a, 3'd4);
    chk("fill_ready_low", wr_ready_a, 1'b0);
    chk("fill_busy", busy_a, 1'b1);
    wr_data_a = sa[5];
    n = 0;
    while (!wr_ready_a && n < 200) begin step(); n++; end
    chk("stall_len", n, FRAME_A - 3);
    chk("full_pop_push_rejected", level_a, 3'd3);
    step();
    chk("push_after_pop", level_a, 3'd4);
    chk("ready_low_again", wr_ready_a, 1'b0);
    wr_valid_a = 1'b0;
    for (int i = 0; i < 400 && (cyc - t0a) < 6 * FRAME_A; i++) step();
    chk("fill_stream_done", (cyc - t0a) >= 6 * FRAME_A, 1'b1);
    chk("fill_busy_end", busy_a, 1'b0);
    chk("fill_level_end", level_a, 3'd0);

    // Reset mid-frame: 0x3C in DATA bit 3 with two bytes queued
    act_a = 1'b0;
    wr_valid_a = 1'b1; wr_data_a = 8'h3C;
    step();
    sa[0] = 8'h3C; na = 1; t0a = cyc + 1; act_a = 1'b1;
    wr_data_a = 8'h81;
    step();
    wr_data_a = 8'h42;
    step();
    wr_valid_a = 1'b0;
    chk("mid_level", level_a, 3'd2);
    for (int i = 0; i < 40 && (cyc - t0a) < 4 * CPB + 1; i++) step();
    chk("mid_bit3", tx_a, 1'b1);
    act_a = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_tx", tx_a, 1'b1);
    chk("mid_rst_level", level_a, 3'd0);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_ready", wr_ready_a, 1'b0);
    rst = 1'b0;
    na = 0; act_a = 1'b1;
    for (int i = 0; i < 2 * FRAME_A; i++) begin
      step();
      chk("post_rst_busy", busy_a, 1'b0);
    end
    act_a = 1'b0;

    // Two stop bits: 0x00 then 0xFF
    wr_valid_b = 1'b1; wr_data_b = 8'h00;
    step();
    sb[0] = 8'h00; sb[1] = 8'hFF; nb = 2; t0b = cyc + 1; act_b = 1'b1;
    wr_data_b = 8'hFF;
    step();
    wr_valid_b = 1'b0;
    chk("stop2_level", level_b, 3'd1);
    for (int i = 1; i < 2 * FRAME_B; i++) begin
      step();
      if (i == 2 * FRAME_B - 1) chk("stop2_busy_last", busy_b, 1'b1);
    end
    step();
    chk("stop2_busy_end", busy_b, 1'b0);
    chk("stop2_level_end", level_b, 3'd0);
    act_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
